dmem_store_buffer: RTL and testbench

Posted-write buffer between the pipeline MEM stage and the SPRAM-backed data cache. Stores are queued in a small FIFO and drained to the cache in the background, so a store costs the pipeline no stall unless the queue is full. Loads are issued to the cache ahead of queued stores unless they hit the same word as a queued store, in which case the queue drains first. The block owns the cache's request pins and turns the cache's `clk_stall` into a one-transaction-at-a-time handshake.

---
 rtl/dmem_store_buffer.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_store_buffer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Posted-write store FIFO in front of the SPRAM data cache. Loads bypass queued
// stores unless they hit a queued word; the cache's clk_stall becomes a handshake.
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_memread,
  input  logic        cpu_memwrite,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic [3:0]  cpu_sign_mask,
  output logic [31:0] cpu_read_data,
  output logic        cpu_stall,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_stall,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {M_IDLE, M_ISSUE, M_WAIT} m_state_e;

  logic [31:0]   fifo_addr_q [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [3:0]    fifo_mask_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  m_state_e      state_q, state_d;
  logic          seen_stall_q, seen_stall_d;
  logic          cur_load_q, cur_load_d;
  logic          ld_pend_q, ld_pend_d;
  logic [31:0]   ld_addr_q, ld_addr_d;
  logic [3:0]    ld_mask_q, ld_mask_d;
  logic          ld_done_q, ld_done_d;
  logic [31:0]   cpu_read_data_q, cpu_read_data_d;
  logic          mem_memread_q, mem_memread_d;
  logic          mem_memwrite_q, mem_memwrite_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_write_data_q, mem_write_data_d;
  logic [3:0]    mem_sign_mask_q, mem_sign_mask_d;

  logic [DEPTH-1:0] hit;
  logic             conflict, complete, pop, push, accept_load, ld_busy;
  logic             load_cand, store_cand, issue;
  logic [AW:0]      rem;
  logic [AW-1:0]    head_nx;

  // An entry is live when its distance from head is below count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      logic [AW-1:0] ofs;
      assign ofs     = AW'(gi) - head_q;
      assign hit[gi] = ({1'b0, ofs} < count_q) &&
                       (fifo_addr_q[gi][31:2] == cpu_addr[31:2]);
    end
  endgenerate

  assign conflict    = |hit;
  assign complete    = (state_q == M_WAIT) && !mem_stall && seen_stall_q;
  assign pop         = complete && !cur_load_q;
  assign ld_busy     = ld_pend_q || ((state_q != M_IDLE) && cur_load_q);
  assign accept_load = cpu_memread && !ld_done_q && !ld_busy && !conflict;
  assign push        = cpu_memwrite && !cpu_memread &&
                       ((count_q < (AW+1)'(DEPTH)) || pop);
  assign rem         = count_q - (AW+1)'(pop);
  assign head_nx     = head_q + AW'(pop);
  assign load_cand   = ld_pend_q || accept_load;
  // A store pushed while nothing else is queued is issued straight from the inputs.
  assign store_cand  = (rem != '0) || push;

  always_comb begin
    cpu_stall = 1'b0;
    if (!reset_n)          cpu_stall = 1'b0;
    else if (cpu_memread)  cpu_stall = !ld_done_q;
    else if (cpu_memwrite) cpu_stall = !push;
  end

  always_comb begin
    state_d          = state_q;
    seen_stall_d     = seen_stall_q;
    cur_load_d       = cur_load_q;
    ld_pend_d        = ld_pend_q;
    ld_addr_d        = ld_addr_q;
    ld_mask_d        = ld_mask_q;
    ld_done_d        = 1'b0;
    cpu_read_data_d  = cpu_read_data_q;
    mem_memread_d    = 1'b0;
    mem_memwrite_d   = 1'b0;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;
    mem_sign_mask_d  = mem_sign_mask_q;
    head_d           = head_nx;
    tail_d           = tail_q + AW'(push);
    count_d          = count_q + (AW+1)'(push) - (AW+1)'(pop);
    issue            = 1'b0;

    if (accept_load) begin
      ld_pend_d = 1'b1;
      ld_addr_d = cpu_addr;
      ld_mask_d = cpu_sign_mask;
    end

    case (state_q)
      M_IDLE: begin
        if (!mem_stall && (load_cand || store_cand)) issue = 1'b1;
      end
      M_ISSUE: begin
        state_d      = M_WAIT;
        seen_stall_d = 1'b0;
      end
      M_WAIT: begin
        if (mem_stall) begin
          seen_stall_d = 1'b1;
        end else if (seen_stall_q) begin
          if (cur_load_q) begin
            cpu_read_data_d = mem_read_data;
            ld_done_d       = 1'b1;
          end
          if (load_cand || store_cand) issue = 1'b1;
          else                         state_d = M_IDLE;
        end
      end
      default: state_d = M_IDLE;
    endcase

    if (issue) begin
      state_d = M_ISSUE;
      if (load_cand) begin
        mem_memread_d   = 1'b1;
        cur_load_d      = 1'b1;
        ld_pend_d       = 1'b0;
        mem_addr_d      = ld_pend_q ? ld_addr_q : cpu_addr;
        mem_sign_mask_d = ld_pend_q ? ld_mask_q : cpu_sign_mask;
      end else if (rem != '0) begin
        mem_memwrite_d   = 1'b1;
        cur_load_d       = 1'b0;
        mem_addr_d       = fifo_addr_q[head_nx];
        mem_write_data_d = fifo_data_q[head_nx];
        mem_sign_mask_d  = fifo_mask_q[head_nx];
      end else begin
        mem_memwrite_d   = 1'b1;
        cur_load_d       = 1'b0;
        mem_addr_d       = cpu_addr;
        mem_write_data_d = cpu_write_data;
        mem_sign_mask_d  = cpu_sign_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= M_IDLE;
      seen_stall_q     <= 1'b0;
      cur_load_q       <= 1'b0;
      ld_pend_q        <= 1'b0;
      ld_addr_q        <= '0;
      ld_mask_q        <= '0;
      ld_done_q        <= 1'b0;
      cpu_read_data_q  <= '0;
      mem_memread_q    <= 1'b0;
      mem_memwrite_q   <= 1'b0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
      mem_sign_mask_q  <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      seen_stall_q     <= seen_stall_d;
      cur_load_q       <= cur_load_d;
      ld_pend_q        <= ld_pend_d;
      ld_addr_q        <= ld_addr_d;
      ld_mask_q        <= ld_mask_d;
      ld_done_q        <= ld_done_d;
      cpu_read_data_q  <= cpu_read_data_d;
      mem_memread_q    <= mem_memread_d;
      mem_memwrite_q   <= mem_memwrite_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
      mem_sign_mask_q  <= mem_sign_mask_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[tail_q] <= cpu_addr;
      fifo_data_q[tail_q] <= cpu_write_data;
      fifo_mask_q[tail_q] <= cpu_sign_mask;
    end
  end

  assign cpu_read_data  = cpu_read_data_q;
  assign mem_memread    = mem_memread_q;
  assign mem_memwrite   = mem_memwrite_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_sign_mask  = mem_sign_mask_q;
  assign empty          = (count_q == '0) && (state_q == M_IDLE) && !ld_pend_q;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: cache model with a 2-cycle clk_stall per request,
// expected cache transactions and load results checked by a scoreboard monitor.
module tb_dmem_store_buffer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_memread, cpu_memwrite;
  logic [31:0] cpu_addr, cpu_write_data;
  logic [3:0]  cpu_sign_mask;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic        mem_memread, mem_memwrite;
  logic [31:0] mem_addr, mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_stall;
  logic        empty;

  dmem_store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
    .cpu_sign_mask(cpu_sign_mask), .cpu_read_data(cpu_read_data),
    .cpu_stall(cpu_stall), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data), .mem_stall(mem_stall), .empty(empty)
  );

  always #5 clk = ~clk;

  // Cache model: each request holds clk_stall for 2 cycles; unwritten words read 0x0BAD_xxxx.
  logic [31:0] cache_mem [256];
  bit          written [256];
  int          stall_cnt = 0;
  logic        force_busy = 1'b0;
  assign mem_stall     = force_busy || (stall_cnt != 0);
  assign mem_read_data = written[mem_addr[9:2]] ? cache_mem[mem_addr[9:2]]
                                                : (32'h0BAD0000 | {22'd0, mem_addr[9:2], 2'b00});
  always @(posedge clk) begin
    if (mem_memread || mem_memwrite) stall_cnt <= 2;
    else if (stall_cnt != 0)         stall_cnt <= stall_cnt - 1;
    if (mem_memwrite) begin
      cache_mem[mem_addr[9:2]] <= mem_write_data;
      written[mem_addr[9:2]]   <= 1'b1;
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } txn_t;
  txn_t        exp_txn[$];
  logic [31:0] exp_rd[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        acc_mem_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    txn_t t;
    t.wr = 1'b1; t.addr = a; t.data = d; t.mask = m;
    exp_txn.push_back(t);
  endtask

  task automatic exp_r(input logic [31:0] a, input logic [3:0] m, input logic [31:0] rd);
    txn_t t;
    t.wr = 1'b0; t.addr = a; t.data = '0; t.mask = m;
    exp_txn.push_back(t);
    exp_rd.push_back(rd);
  endtask

  // Monitor: pops an expectation for every cache request and every finished load.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_memread || mem_memwrite) begin
        n_cmp++;
        $display("txn %s addr=%h data=%h mask=%h", mem_memwrite ? "WR" : "RD",
                 mem_addr, mem_write_data, mem_sign_mask);
        if (exp_txn.size() == 0) begin
          n_fail++;
          $display("FAIL txn_unexpected: got wr=%0b addr=%h required none", mem_memwrite, mem_addr);
        end else begin
          txn_t e;
          e = exp_txn.pop_front();
          if ((mem_memread && mem_memwrite) || (e.wr != mem_memwrite) || (e.addr != mem_addr) ||
              (e.mask != mem_sign_mask) || (e.wr && (e.data != mem_write_data))) begin
            n_fail++;
            $display("FAIL txn_order: got wr=%0b addr=%h data=%h mask=%h required wr=%0b addr=%h data=%h mask=%h",
                     mem_memwrite, mem_addr, mem_write_data, mem_sign_mask, e.wr, e.addr, e.data, e.mask);
          end
        end
      end
      if (reset_n && cpu_memread && !cpu_stall) begin
        n_cmp++;
        if (exp_rd.size() == 0) begin
          n_fail++;
          $display("FAIL load_unexpected: got %h required none", cpu_read_data);
        end else begin
          logic [31:0] r;
          r = exp_rd.pop_front();
          $display("load result %h", cpu_read_data);
          if (cpu_read_data !== r) begin
            n_fail++;
            $display("FAIL load_data: got %h required %h", cpu_read_data, r);
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepts the store.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          output int stall_cyc);
    cpu_memwrite = 1'b1; cpu_addr = a; cpu_write_data = d; cpu_sign_mask = m;
    stall_cyc = 0;
    @(negedge clk);
    while (cpu_stall && stall_cyc < 200) begin
      stall_cyc++;
      @(negedge clk);
    end
    if (cpu_stall) begin
      n_cmp++; n_fail++;
      $display("FAIL store_timeout: got stall after %0d cycles required accept", stall_cyc);
    end
    acc_mem_stall = mem_stall;
    @(posedge clk); #1;
    cpu_memwrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] m, input logic with_store,
                         output int stall_cyc);
    cpu_memread = 1'b1; cpu_memwrite = with_store; cpu_addr = a;
    cpu_write_data = 32'hBAD0BAD0; cpu_sign_mask = m;
    stall_cyc = 0;
    @(negedge clk);
    while (cpu_stall && stall_cyc < 200) begin
      stall_cyc++;
      @(negedge clk);
    end
    if (cpu_stall) begin
      n_cmp++; n_fail++;
      $display("FAIL load_timeout: got stall after %0d cycles required completion", stall_cyc);
    end
    @(posedge clk); #1;
    cpu_memread = 1'b0; cpu_memwrite = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!empty && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!empty) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: got empty=0 required 1");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    reset_n = 1'b0; cpu_memread = 1'b0; cpu_memwrite = 1'b0;
    cpu_addr = '0; cpu_write_data = '0; cpu_sign_mask = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_memread", {31'd0, mem_memread}, 32'd0);
    chk("rst_memwrite", {31'd0, mem_memwrite}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_idle();

    // Single store into an empty buffer: no stall, issued next cycle, empty 4 cycles later.
    exp_w(32'h100, 32'hDEADBEEF, 4'h7);
    do_store(32'h100, 32'hDEADBEEF, 4'h7, st);
    chk("store_no_stall", st, 0);
    @(negedge clk);
    chk("store_issue_next", {31'd0, mem_memwrite}, 32'd1);
    chk("store_issue_addr", mem_addr, 32'h100);
    repeat (3) @(negedge clk);
    chk("empty_before", {31'd0, empty}, 32'd0);
    @(negedge clk);
    chk("empty_after", {31'd0, empty}, 32'd1);
    wait_idle();

    // Full FIFO: fifth store stalls until the first pop and is accepted in that cycle.
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) exp_w(32'h140 + 32'(i * 4), 32'hA0000001 + 32'(i), 4'hF);
    for (int i = 0; i < 4; i++) begin
      do_store(32'h140 + 32'(i * 4), 32'hA0000001 + 32'(i), 4'hF, st);
      chk("fill_no_stall", st, 0);
    end
    fork
      begin repeat (6) @(posedge clk); #1 force_busy = 1'b0; end
      do_store(32'h150, 32'hA0000005, 4'hF, st);
    join
    chk("full_stall_cycles", st, 10);
    chk("accept_in_pop_cycle", {31'd0, acc_mem_stall}, 32'd0);
    wait_idle();

    // Unloaded load: 5 stall cycles, data valid when stall drops.
    exp_r(32'h30C, 4'hF, 32'h0BAD030C);
    do_load(32'h30C, 4'hF, 1'b0, st);
    chk("load_latency", st, 5);
    wait_idle();

    // Load bypasses two queued stores.
    force_busy = 1'b1;
    exp_r(32'h304, 4'h7, 32'h0BAD0304);
    exp_w(32'h200, 32'h11112222, 4'h7);
    exp_w(32'h204, 32'h33334444, 4'h7);
    do_store(32'h200, 32'h11112222, 4'h7, st);
    do_store(32'h204, 32'h33334444, 4'h7, st);
    fork
      begin repeat (3) @(posedge clk); #1 force_busy = 1'b0; end
      do_load(32'h304, 4'h7, 1'b0, st);
    join
    wait_idle();

    // Same-word load waits for the queued store and sees its data.
    force_busy = 1'b1;
    exp_w(32'h208, 32'h12345678, 4'h7);
    exp_r(32'h20A, 4'hF, 32'h12345678);
    do_store(32'h208, 32'h12345678, 4'h7, st);
    fork
      begin repeat (3) @(posedge clk); #1 force_busy = 1'b0; end
      do_load(32'h20A, 4'hF, 1'b0, st);
    join
    wait_idle();

    // Load and store together: only the load is taken.
    exp_r(32'h300, 4'h7, 32'h0BAD0300);
    do_load(32'h300, 4'h7, 1'b1, st);
    chk("both_high_latency", st, 5);
    wait_idle();

    // Reset while a store is in flight and another queued.
    exp_w(32'h2000, 32'h000000A5, 4'h7);
    do_store(32'h2000, 32'h000000A5, 4'h7, st);
    do_store(32'h240, 32'h24024024, 4'h7, st);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall_in", {31'd0, mem_stall}, 32'd1);
    chk("rst_mid_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_w(32'h280, 32'hC0C0C0C0, 4'h3);
    cpu_memwrite = 1'b1; cpu_addr = 32'h280; cpu_write_data = 32'hC0C0C0C0; cpu_sign_mask = 4'h3;
    @(negedge clk);
    chk("rst2_memread", {31'd0, mem_memread}, 32'd0);
    chk("rst2_memwrite", {31'd0, mem_memwrite}, 32'd0);
    chk("rst2_mem_addr", mem_addr, 32'd0);
    chk("rst2_mem_wdata", mem_write_data, 32'd0);
    chk("rst2_mem_mask", {28'd0, mem_sign_mask}, 32'd0);
    chk("rst2_cpu_rdata", cpu_read_data, 32'd0);
    chk("rst2_empty", {31'd0, empty}, 32'd1);
    chk("rst2_store_accept", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1;
    cpu_memwrite = 1'b0;
    @(negedge clk);
    chk("no_issue_while_stall", {31'd0, mem_memwrite}, 32'd0);
    @(negedge clk);
    chk("issue_after_stall", {31'd0, mem_memwrite}, 32'd1);
    chk("issue_after_addr", mem_addr, 32'h280);
    wait_idle();

    // 20 random stores through the wrapping FIFO.
    for (int i = 0; i < 20; i++) begin
      int          r;
      logic [31:0] a, d;
      r = int'($urandom_range(0, 255));
      a = 32'(r) << 2;
      d = $urandom;
      exp_w(a, d, 4'hF);
      do_store(a, d, 4'hF, st);
    end
    wait_idle();
    repeat (4) @(negedge clk);

    chk("txn_queue_drained", exp_txn.size(), 0);
    chk("load_queue_drained", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
